hex_segment_decoder: RTL and testbench
======================================

// Module: hex_segment_decoder
// PURPOSE
//  Inverse of the FTW hex-display encoder: takes the 8-digit active-low seven-segment bus and
//  recovers the 32-bit hex value, one digit per clock, MSB digit first. Checks the bus is
//  canonical encoder output (legal glyphs, leading-zero blanking). Used as a loopback monitor
//  on the DDS display path and as a self-check for FTW readback.
// PARAMETERS
//  NUM_DIGITS  8  digits on the bus; value width = 4*NUM_DIGITS, err_digit width = $clog2(NUM_DIGITS)
// PORTS
//  clk        in   1             single system clock, rising edge
//  rst_n      in   1             asynchronous, active-low reset
//  start      in   1             request conversion; sampled in IDLE only
//  seg_in     in   7*NUM_DIGITS  segment bus, digit i at [7i+6:7i], bit0=a..bit6=g, 0=lit
//  busy       out  1             conversion in progress
//  done       out  1             one-cycle pulse: value/err/err_digit updated
//  value      out  4*NUM_DIGITS  decoded hex value
//  err        out  1             bus was not a canonical encoder pattern
//  err_digit  out  $clog2(ND)    index of first (highest) offending digit
// BEHAVIOUR
//  - Reset: busy=0, done=0, value=0, err=0, err_digit=0; FSM->IDLE. Async assert aborts any scan;
//    no done is issued for the aborted conversion.
//  - FSM IDLE->SCAN->DONE->IDLE. IDLE: start=1 at edge t latches seg_in into shadow reg, idx=ND-1,
//    acc=0, err=0. SCAN: one digit per cycle, idx ND-1 down to 0 (edges t+1..t+ND). DONE: done=1
//    for exactly one cycle (edge t+ND+1); value/err/err_digit loaded then, held until next done.
//  - busy=1 in SCAN and DONE. start while busy (incl. DONE cycle) ignored; no queueing.
//  - Glyphs (7'b gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010
//    7=1111000 8=0000000 9=0011000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110
//    blank=1111111.
//  - Per digit: acc <= {acc[4*ND-5:0], nib}. leading = no non-blank digit seen yet this scan.
//    glyph while leading: nib=glyph; if glyph==0 and idx!=0 -> error (encoder blanks lead zeros).
//    blank while leading, idx!=0: nib=0, legal. blank at idx 0: error (digit 0 never blanked).
//    blank after non-blank: error, nib=0. unknown pattern: error, nib=0.
//  - Error sticky per conversion; err_digit records first error only (highest index).
//  - seg_in changing during SCAN has no effect (shadow copy).
// CONFIGURATION
//  SEG_INPUT_SYNC_EN defined: seg_in and start each pass a 2-flop synchronizer (reset to
//  all-ones/0) before the FSM; start-to-done latency becomes ND+3 edges.
//  Undefined: direct sampling, start-to-done latency ND+1 edges.
// TESTING
//  1 seg_in = blanks d7..d2, '1' d1, '0' d0; start -> done at t+9, value=32'h00000010, err=0.
//  2 seg_in = DEADBEEF glyphs -> value=32'hDEADBEEF, err=0; busy high t+1..t+9 only.
//  3 all digits blank -> value=0, err=1, err_digit=0.
//  4 d5=7'b1010101, rest legal '1' -> err=1, err_digit=5; d7='0' glyph, d6='1' -> err_digit=7.
//  5 d4='1', d3 blank, d2..d0 '2' -> err=1, err_digit=3; start pulsed at t+3 ignored, one done.
//  6 rst_n low at t+4 mid-scan -> busy=0, value=0 immediately, no done; new start then converts
//    normally. Repeat test 1 with SEG_INPUT_SYNC_EN -> done at t+11.

Source files
------------

// File: rtl/hex_segment_decoder.sv
// Recovers a hex value from an active-low 7-seg bus, MSB digit first; done ND+1 edges after start (ND+3 with SEG_INPUT_SYNC_EN).
// No backpressure: start is taken only when idle, and a start while busy is dropped.
module hex_segment_decoder #(
  parameter int NUM_DIGITS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [7*NUM_DIGITS-1:0]       seg_in,
  output logic                          busy,
  output logic                          done,
  output logic [4*NUM_DIGITS-1:0]       value,
  output logic                          err,
  output logic [$clog2(NUM_DIGITS)-1:0] err_digit
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [6:0] BLANK = 7'b1111111;

  logic [1:0]    state;
  logic [SW-1:0] shadow;
  logic [IW-1:0] idx;
  logic [VW-1:0] acc;
  logic          leading;
  logic          err_acc;
  logic [IW-1:0] err_idx;

  logic          start_q;
  logic [SW-1:0] seg_q;

`ifdef SEG_INPUT_SYNC_EN
  logic          start_s1;
  logic [SW-1:0] seg_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_s1 <= 1'b0;
      start_q  <= 1'b0;
      seg_s1   <= '1;
      seg_q    <= '1;
    end else begin
      start_s1 <= start;
      start_q  <= start_s1;
      seg_s1   <= seg_in;
      seg_q    <= seg_s1;
    end
  end
`else
  assign start_q = start;
  assign seg_q   = seg_in;
`endif

  // Returns {known, nibble}; anything not in the glyph table is unknown.
  function automatic logic [4:0] decode_glyph(input logic [6:0] p);
    case (p)
      7'b1000000: decode_glyph = 5'h10;
      7'b1111001: decode_glyph = 5'h11;
      7'b0100100: decode_glyph = 5'h12;
      7'b0110000: decode_glyph = 5'h13;
      7'b0011001: decode_glyph = 5'h14;
      7'b0010010: decode_glyph = 5'h15;
      7'b0000010: decode_glyph = 5'h16;
      7'b1111000: decode_glyph = 5'h17;
      7'b0000000: decode_glyph = 5'h18;
      7'b0011000: decode_glyph = 5'h19;
      7'b0001000: decode_glyph = 5'h1A;
      7'b0000011: decode_glyph = 5'h1B;
      7'b1000110: decode_glyph = 5'h1C;
      7'b0100001: decode_glyph = 5'h1D;
      7'b0000110: decode_glyph = 5'h1E;
      7'b0001110: decode_glyph = 5'h1F;
      default:    decode_glyph = 5'h00;
    endcase
  endfunction

  logic [6:0] cur;
  logic [4:0] dec;
  logic       is_blank;
  logic       is_last;
  logic       dig_err;
  logic [3:0] nib;

  always_comb begin
    cur = BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == i[IW-1:0]) cur = shadow[7*i +: 7];
    end
  end

  always_comb begin
    dec      = decode_glyph(cur);
    is_blank = (cur == BLANK);
    is_last  = (idx == '0);
    dig_err  = 1'b0;
    nib      = 4'h0;
    if (is_blank) begin
      // Only leading positions may be blanked, and digit 0 is always shown.
      dig_err = !leading || is_last;
    end else if (dec[4]) begin
      nib     = dec[3:0];
      dig_err = leading && (dec[3:0] == 4'h0) && !is_last;
    end else begin
      dig_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shadow    <= '1;
      idx       <= '0;
      acc       <= '0;
      leading   <= 1'b1;
      err_acc   <= 1'b0;
      err_idx   <= '0;
      done      <= 1'b0;
      value     <= '0;
      err       <= 1'b0;
      err_digit <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The done cycle is still part of the busy window, so start is refused there too.
          if (start_q && !done) begin
            state   <= ST_SCAN;
            shadow  <= seg_q;
            idx     <= IW'(NUM_DIGITS - 1);
            acc     <= '0;
            leading <= 1'b1;
            err_acc <= 1'b0;
            err_idx <= '0;
          end
        end
        ST_SCAN: begin
          acc <= {acc[VW-5:0], nib};
          if (!is_blank) leading <= 1'b0;
          if (dig_err && !err_acc) begin
            err_acc <= 1'b1;
            err_idx <= idx;
          end
          if (is_last) state <= ST_DONE;
          else         idx   <= idx - 1'b1;
        end
        ST_DONE: begin
          done      <= 1'b1;
          value     <= acc;
          err       <= err_acc;
          err_digit <= err_idx;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE) || done;

endmodule

// File: tb/tb_hex_segment_decoder.sv
// Directed bench for hex_segment_decoder: canonical patterns, glyph errors, ignored start, mid-scan reset.
module tb_hex_segment_decoder;

  localparam int ND = 8;
`ifdef SEG_INPUT_SYNC_EN
  localparam int LAT = ND + 3;
`else
  localparam int LAT = ND + 1;
`endif

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GD = 7'b0100001;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] BAD = 7'b1010101;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [7*ND-1:0] seg_in;
  logic            busy;
  logic            done;
  logic [4*ND-1:0] value;
  logic            err;
  logic [2:0]      err_digit;

  int total;
  int bad;

  int          lat;
  int          ndone;
  logic [31:0] busy_hist;

  hex_segment_decoder #(.NUM_DIGITS(ND)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seg_in    (seg_in),
    .busy      (busy),
    .done      (done),
    .value     (value),
    .err       (err),
    .err_digit (err_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents seg, pulses start into edge t, then watches 16 edges. A second start
  // is applied before edge t+restart when restart is nonzero.
  task automatic convert(input logic [7*ND-1:0] seg, input int restart);
    seg_in    = seg;
    start     = 1'b1;
    lat       = 0;
    ndone     = 0;
    busy_hist = '0;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 16; k++) begin
      start = (k == restart);
      @(posedge clk);
      #1;
      busy_hist[k] = busy;
      if (done) begin
        ndone++;
        if (lat == 0) lat = k;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    seg_in = {ND{BL}};
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_value", value, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_digit", 32'(err_digit), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: ...10
    convert({BL, BL, BL, BL, BL, BL, G1, G0}, 0);
    check("t1_latency", lat, LAT);
    check("t1_done_count", ndone, 1);
    check("t1_value", value, 32'h00000010);
    check("t1_err", 32'(err), 32'd0);

    // 2: DEADBEEF and busy window
    convert({GD, GE, GA, GD, GB, GE, GE, GF}, 0);
    check("t2_latency", lat, LAT);
    check("t2_value", value, 32'hDEADBEEF);
    check("t2_err", 32'(err), 32'd0);
    check("t2_busy_first", 32'(busy_hist[1]), 32'd1);
    check("t2_busy_done_cycle", 32'(busy_hist[LAT]), 32'd1);
    check("t2_busy_after", 32'(busy_hist[LAT+1]), 32'd0);

    // 3: all blank, digit 0 must not be blanked
    convert({ND{BL}}, 0);
    check("t3_value", value, 32'h0);
    check("t3_err", 32'(err), 32'd1);
    check("t3_err_digit", 32'(err_digit), 32'd0);

    // 4a: unknown pattern on digit 5
    convert({G1, G1, BAD, G1, G1, G1, G1, G1}, 0);
    check("t4a_err", 32'(err), 32'd1);
    check("t4a_err_digit", 32'(err_digit), 32'd5);
    check("t4a_value", value, 32'h11011111);

    // 4b: leading zero glyph on digit 7
    convert({G0, G1, G1, G1, G1, G1, G1, G1}, 0);
    check("t4b_err", 32'(err), 32'd1);
    check("t4b_err_digit", 32'(err_digit), 32'd7);

    // 5: blank after a non-blank digit, extra start mid-scan dropped
    convert({BL, BL, BL, G1, BL, G2, G2, G2}, 3);
    check("t5_err", 32'(err), 32'd1);
    check("t5_err_digit", 32'(err_digit), 32'd3);
    check("t5_value", value, 32'h00010222);
    check("t5_done_count", ndone, 1);
    check("t5_latency", lat, LAT);

    // 6: reset in the middle of a scan
    seg_in = {GD, GE, GA, GD, GB, GE, GE, GF};
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy_in_reset", 32'(busy), 32'd0);
    check("t6_value_in_reset", value, 32'h0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (k == 3) rst_n = 1'b1;
    end
    check("t6_no_done_after_abort", ndone, 0);
    convert({BL, BL, BL, BL, BL, BL, G1, G0}, 0);
    check("t6_latency", lat, LAT);
    check("t6_value", value, 32'h00000010);
    check("t6_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
